instr_fetch_queue: RTL and testbench
====================================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; SHALL be a power of two in the range 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 Clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Rst  input  1  synchronous, active-high reset, sampled on rising Clk.
REQ-005 InstrAddr  output  32  fetch PC driven to the combinational InstructionMemory (word index = InstrAddr[11:2]).
REQ-006 InstrData  input  32  instruction returned combinationally for InstrAddr in the same cycle.
REQ-007 Stall  input  1  decode cannot accept; the head entry SHALL NOT be popped.
REQ-008 Redirect  input  1  taken branch/jump; flush the queue and refetch.
REQ-009 RedirectAddr  input  32  new fetch PC, valid when Redirect=1.
REQ-010 Instruction_Out  output  32  head instruction, feeds IF_ID_Register.
REQ-011 PCAddResult_Out  output  32  head PC+4, feeds IF_ID_Register.
REQ-012 Valid_Out  output  1  head entry valid.
REQ-013 Count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-014 Fetch PC register SHALL drive InstrAddr; each entry SHALL hold {PC+4, InstrData}.
REQ-015 Push SHALL occur when Redirect=0 and (Count<DEPTH or pop occurs this cycle); on push PC SHALL advance by 4, wrapping modulo 2^32.
REQ-016 Pop SHALL occur when Valid_Out=1, Stall=0, Redirect=0.
REQ-017 Valid_Out SHALL equal (Count!=0); when Valid_Out=0, Instruction_Out SHALL be 32'h0000_0000 (NOP) and PCAddResult_Out SHALL be 32'h0.
REQ-018 Without bypass, latency from fetch to visibility on Instruction_Out SHALL be exactly one cycle.
REQ-019 Simultaneous push and pop SHALL leave Count unchanged; full with pop SHALL still push.
REQ-020 Full with no pop: no push, PC held, InstrAddr unchanged.
REQ-021 Empty with Stall=1: push proceeds normally; Stall SHALL only block pops.
REQ-022 Redirect=1 SHALL, on that edge: clear all entries (Count=0), suppress push and pop, load PC with {RedirectAddr[31:2],2'b00}; Valid_Out SHALL be 0 the following cycle.
REQ-023 Redirect SHALL take priority over Stall, push and pop.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH; entries SHALL be returned in fetch order.

Reset
REQ-025 Rst=1 SHALL set PC=RESET_PC, pointers=0, Count=0, Valid_Out=0, Instruction_Out=0, PCAddResult_Out=0.
REQ-026 Rst SHALL take priority over Redirect and all other inputs; reset mid-stream SHALL discard all entries.
REQ-027 First push SHALL occur on the first rising edge after Rst deasserts.

Configuration
REQ-028 Macro FETCHQ_BYPASS_EN: when defined, with Count=0, Stall=0, Redirect=0, InstrData and PC+4 SHALL appear combinationally on Instruction_Out/PCAddResult_Out with Valid_Out=1 in the fetch cycle, and the entry SHALL NOT be stored; when undefined, REQ-018 latency of one cycle SHALL always apply.
REQ-029 Count SHALL exclude the bypassed entry in both builds.

Verification
REQ-030 Reset release, Stall=0, memory word k = k: Instruction_Out sequence 0,1,2,... with PCAddResult_Out 4,8,12,...; Valid_Out first high cycle 1 after reset (cycle 0 with FETCHQ_BYPASS_EN).
REQ-031 Stall=1 for 8 cycles, DEPTH=4: Count saturates at 4, InstrAddr holds 32'h10, head stays instruction 0; after release, output continues 0,1,2,3,4 without gap or duplicate.
REQ-032 Full queue, Redirect=1 RedirectAddr=32'h0000_0103: next cycle Count=0, Valid_Out=0, InstrAddr=32'h100; following cycle Instruction_Out=mem[64], PCAddResult_Out=32'h104.
REQ-033 Redirect and Stall both high: flush occurs, head not held; Rst and Redirect both high: PC=RESET_PC.
REQ-034 Random Stall (50%) over 1000 cycles with scoreboard: every fetched instruction popped once, in order; Count never exceeds DEPTH.
REQ-035 PC=32'hFFFF_FFFC push: PC wraps to 32'h0000_0000, PCAddResult_Out=32'h0.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: a fetch PC drives a combinational instruction memory and each
// fetched word is stored with its PC+4 in a small circular queue that feeds IF/ID.
// A redirect flushes the queue and reloads the PC. DEPTH must be a power of two, 2..16.
// Optional build macro FETCHQ_BYPASS_EN: when the queue is empty and decode is ready,
// the word being fetched is forwarded straight to the outputs instead of being stored.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     Clk,
  input  logic                     Rst,
  output logic [31:0]              InstrAddr,
  input  logic [31:0]              InstrData,
  input  logic                     Stall,
  input  logic                     Redirect,
  input  logic [31:0]              RedirectAddr,
  output logic [31:0]              Instruction_Out,
  output logic [31:0]              PCAddResult_Out,
  output logic                     Valid_Out,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [31:0]      instr_q [DEPTH];
  logic [31:0]      pc4_q   [DEPTH];

  logic [31:0]      pc_plus4;
  logic             head_valid;
  logic             bypass;
  logic             pop;
  logic             push;

  assign pc_plus4   = pc_q + 32'd4;
  assign head_valid = (count_q != '0);

`ifdef FETCHQ_BYPASS_EN
  // Empty queue and decode ready: hand the fetched word over directly, nothing is stored.
  assign bypass = (count_q == '0) && !Stall && !Redirect && !Rst;
`else
  assign bypass = 1'b0;
`endif

  // Redirect suppresses both queue operations; a pop frees a slot so a full queue can push.
  assign pop  = head_valid && !Stall && !Redirect;
  assign push = !Redirect && !bypass && ((count_q != Full) || pop);

  // Next-state for fetch PC, pointers and occupancy.
  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (Redirect) begin
      pc_d     = {RedirectAddr[31:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push || bypass) begin
        pc_d = pc_plus4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  // State register with synchronous reset; reset overrides redirect and everything else.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge Clk) begin
    if (!Rst && push) begin
      instr_q[wr_ptr_q] <= InstrData;
      pc4_q[wr_ptr_q]   <= pc_plus4;
    end
  end

  // Head presentation: bypassed word, stored head, or NOP when nothing is valid.
  always_comb begin
    Valid_Out       = 1'b0;
    Instruction_Out = 32'h0000_0000;
    PCAddResult_Out = 32'h0000_0000;
    if (bypass) begin
      Valid_Out       = 1'b1;
      Instruction_Out = InstrData;
      PCAddResult_Out = pc_plus4;
    end else if (head_valid) begin
      Valid_Out       = 1'b1;
      Instruction_Out = instr_q[rd_ptr_q];
      PCAddResult_Out = pc4_q[rd_ptr_q];
    end
  end

  assign InstrAddr = pc_q;
  assign Count     = count_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios plus a randomized run
// compared against a queue-based reference model of the fetch/flush rules.
module tb_instr_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        Clk;
  logic        Rst;
  logic [31:0] InstrAddr;
  logic [31:0] InstrData;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectAddr;
  logic [31:0] Instruction_Out;
  logic [31:0] PCAddResult_Out;
  logic        Valid_Out;
  logic [2:0]  Count;

  logic [31:0] mem [1024];
  assign InstrData = mem[InstrAddr[11:2]];

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mpc = RESET_PC;

  instr_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .InstrAddr       (InstrAddr),
    .InstrData       (InstrData),
    .Stall           (Stall),
    .Redirect        (Redirect),
    .RedirectAddr    (RedirectAddr),
    .Instruction_Out (Instruction_Out),
    .PCAddResult_Out (PCAddResult_Out),
    .Valid_Out       (Valid_Out),
    .Count           (Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Expected head as seen by decode for the current model state and inputs.
  function automatic void model_out(output logic v, output logic [31:0] ins,
                                    output logic [31:0] p4);
    v = 1'b0; ins = 32'h0; p4 = 32'h0;
`ifdef FETCHQ_BYPASS_EN
    if (mq.size() == 0 && !Stall && !Redirect && !Rst) begin
      v = 1'b1; ins = mem[mpc[11:2]]; p4 = mpc + 32'd4;
      return;
    end
`endif
    if (mq.size() != 0) begin
      v = 1'b1; ins = mq[0].instr; p4 = mq[0].pc4;
    end
  endfunction

  task automatic drive(input logic rst, input logic st, input logic rd, input logic [31:0] ra);
    @(negedge Clk);
    Rst = rst; Stall = st; Redirect = rd; RedirectAddr = ra;
    #1;
  endtask

  // Apply the clock edge to the model, then let the DUT take the same edge.
  task automatic advance();
    ent_t e;
    bit   done;
    bit   pop;
    bit   push;
    done = 1'b0;
    if (Rst) begin
      mq.delete(); mpc = RESET_PC;
    end else if (Redirect) begin
      mq.delete(); mpc = {RedirectAddr[31:2], 2'b00};
    end else begin
`ifdef FETCHQ_BYPASS_EN
      if (mq.size() == 0 && !Stall) begin
        done = 1'b1; mpc = mpc + 32'd4;
      end
`endif
      if (!done) begin
        pop  = (mq.size() != 0) && !Stall;
        push = (mq.size() < int'(DEPTH)) || pop;
        e.pc4 = mpc + 32'd4;
        e.instr = mem[mpc[11:2]];
        if (pop) void'(mq.pop_front());
        if (push) begin
          mq.push_back(e); mpc = mpc + 32'd4;
        end
      end
    end
    @(posedge Clk);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    advance();
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if (Count !== 3'd0) begin
      errors++; $display("FAIL reset_count got=%0d exp=0", Count);
    end
    checks++;
    if (Valid_Out !== 1'b0 || Instruction_Out !== 32'h0 || PCAddResult_Out !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b i=%h p=%h exp v=0 i=0 p=0",
               Valid_Out, Instruction_Out, PCAddResult_Out);
    end
    checks++;
    if (InstrAddr !== RESET_PC) begin
      errors++; $display("FAIL reset_pc got=%h exp=%h", InstrAddr, RESET_PC);
    end
    advance();
    // Mid-stream reset with a redirect pending must discard entries and restore RESET_PC.
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      advance();
    end
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0400);
    advance();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (Count !== 3'd0 || Valid_Out !== 1'b0 || InstrAddr !== RESET_PC) begin
      errors++;
      $display("FAIL reset_midstream got cnt=%0d v=%b pc=%h exp cnt=0 v=0 pc=%h",
               Count, Valid_Out, InstrAddr, RESET_PC);
    end
    advance();
  endtask

  task automatic test_sequence();
    logic        ev;
    logic [31:0] ei;
    logic [31:0] ep;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0);
`ifdef FETCHQ_BYPASS_EN
      ev = 1'b1; ei = 32'(c); ep = 32'(4 * (c + 1));
`else
      ev = (c >= 1);
      ei = (c >= 1) ? 32'(c - 1) : 32'h0;
      ep = (c >= 1) ? 32'(4 * c) : 32'h0;
`endif
      checks++;
      if (Valid_Out !== ev || Instruction_Out !== ei || PCAddResult_Out !== ep) begin
        errors++;
        $display("FAIL seq_c%0d got v=%b i=%h p=%h exp v=%b i=%h p=%h", c,
                 Valid_Out, Instruction_Out, PCAddResult_Out, ev, ei, ep);
      end
      advance();
    end
  endtask

  task automatic test_stall_full();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      checks++;
      if (Count !== 3'((c < 4) ? c : 4)) begin
        errors++; $display("FAIL stall_count_c%0d got=%0d exp=%0d", c, Count, (c < 4) ? c : 4);
      end
      if (c >= 1) begin
        checks++;
        if (Valid_Out !== 1'b1 || Instruction_Out !== 32'h0) begin
          errors++;
          $display("FAIL stall_head_c%0d got v=%b i=%h exp v=1 i=0", c, Valid_Out, Instruction_Out);
        end
      end
      if (c == 7) begin
        checks++;
        if (InstrAddr !== 32'h10) begin
          errors++; $display("FAIL stall_pc_hold got=%h exp=00000010", InstrAddr);
        end
      end
      advance();
    end
    for (int r = 0; r < 5; r++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      checks++;
      if (Valid_Out !== 1'b1 || Instruction_Out !== 32'(r)) begin
        errors++;
        $display("FAIL release_r%0d got v=%b i=%h exp v=1 i=%h", r, Valid_Out, Instruction_Out, r);
      end
      advance();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      advance();
    end
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0103);
    advance();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (Count !== 3'd0 || Valid_Out !== 1'b0 || InstrAddr !== 32'h100) begin
      errors++;
      $display("FAIL redirect_flush got cnt=%0d v=%b pc=%h exp cnt=0 v=0 pc=00000100",
               Count, Valid_Out, InstrAddr);
    end
    advance();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (Instruction_Out !== 32'd64 || PCAddResult_Out !== 32'h104 || Count !== 3'd1) begin
      errors++;
      $display("FAIL redirect_refetch got i=%h p=%h cnt=%0d exp i=00000040 p=00000104 cnt=1",
               Instruction_Out, PCAddResult_Out, Count);
    end
    advance();
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      advance();
    end
    // Redirect wins over Stall: the held head must still be flushed.
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0203);
    advance();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (Count !== 3'd0 || Valid_Out !== 1'b0 || InstrAddr !== 32'h200) begin
      errors++;
      $display("FAIL redirect_stall got cnt=%0d v=%b pc=%h exp cnt=0 v=0 pc=00000200",
               Count, Valid_Out, InstrAddr);
    end
    advance();
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0300);
    advance();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (InstrAddr !== RESET_PC || Count !== 3'd0) begin
      errors++;
      $display("FAIL rst_over_redirect got pc=%h cnt=%0d exp pc=%h cnt=0",
               InstrAddr, Count, RESET_PC);
    end
    advance();
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    advance();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (InstrAddr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_pc_load got=%h exp=fffffffc", InstrAddr);
    end
    advance();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (InstrAddr !== 32'h0 || PCAddResult_Out !== 32'h0 || Instruction_Out !== 32'd1023 ||
        Valid_Out !== 1'b1) begin
      errors++;
      $display("FAIL wrap_result got pc=%h p=%h i=%h v=%b exp pc=0 p=0 i=000003ff v=1",
               InstrAddr, PCAddResult_Out, Instruction_Out, Valid_Out);
    end
    advance();
  endtask

  task automatic test_random();
    logic        ev;
    logic [31:0] ei;
    logic [31:0] ep;
    logic        st;
    logic        rd;
    logic        rs;
    for (int k = 0; k < 1024; k++) mem[k] = $urandom;
    do_reset();
    for (int c = 0; c < 1000; c++) begin
      rs = ($urandom_range(0, 199) == 0);
      rd = ($urandom_range(0, 29) == 0);
      st = $urandom_range(0, 1) == 1;
      drive(rs, st, rd, $urandom);
      model_out(ev, ei, ep);
      checks++;
      if (Valid_Out !== ev || Instruction_Out !== ei || PCAddResult_Out !== ep) begin
        errors++;
        $display("FAIL rand_head_c%0d got v=%b i=%h p=%h exp v=%b i=%h p=%h", c,
                 Valid_Out, Instruction_Out, PCAddResult_Out, ev, ei, ep);
      end
      checks++;
      if (Count !== 3'(mq.size()) || Count > 3'(DEPTH)) begin
        errors++; $display("FAIL rand_count_c%0d got=%0d exp=%0d", c, Count, mq.size());
      end
      checks++;
      if (InstrAddr !== mpc) begin
        errors++; $display("FAIL rand_pc_c%0d got=%h exp=%h", c, InstrAddr, mpc);
      end
      advance();
    end
  endtask

  initial begin
    Rst = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectAddr = 32'h0;
    for (int k = 0; k < 1024; k++) mem[k] = 32'(k);
    test_reset();
    test_sequence();
    test_stall_full();
    test_redirect();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
